// File: rtl/cycle_sequencer.sv
// Instruction cycle sequencer: tracks the cycle within an instruction, latches the
// next opcode on each instruction boundary, and arbitrates reset/NMI/IRQ injection.
module cycle_sequencer #(
    parameter logic [7:0] INT_OP = 8'h00
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       rdy,
    input  logic       icyc,
    input  logic       rcyc,
    input  logic       sinst,
    input  logic [7:0] data_in,
    input  logic       irq,
    input  logic       nmi,
    input  logic       idis,
    output logic [2:0] cycle,
    output logic [7:0] inst,
    output logic       clr_o,
    output logic       nmi_o,
    output logic       irq_o,
    output logic       sync,
    output logic       err
);

    // Handshake: rdy is a plain advance enable. A request on icyc/rcyc/sinst is
    // accepted only on a rising clk edge with rdy=1; with rdy=0 it is ignored and
    // the decoder must keep presenting it. Interrupt capture ignores rdy.

    logic clr_pend;
    logic nmi_pend;
    logic nmi_q;
    logic nmi_rise;
    logic seq_start;
    logic inject;

    always_comb begin
        clr_o     = clr_pend;
        nmi_o     = nmi_pend & ~clr_pend;
        irq_o     = irq & ~idis & ~clr_pend & ~nmi_pend;
        inject    = clr_o | nmi_o | irq_o;
        nmi_rise  = nmi & ~nmi_q;
        seq_start = rdy & sinst & (cycle == 3'd0);
    end

    // Interrupt capture runs every clock, independent of rdy.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            clr_pend <= 1'b1;
            nmi_pend <= 1'b0;
            nmi_q    <= 1'b0;
        end else begin
            nmi_q <= nmi;
            if (seq_start && clr_o) begin
                clr_pend <= 1'b0;
            end
            // A fresh edge wins over the acknowledge so a back-to-back NMI is not lost.
            if (nmi_rise) begin
                nmi_pend <= 1'b1;
            end else if (seq_start && nmi_o) begin
                nmi_pend <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            cycle <= 3'd0;
            inst  <= INT_OP;
            sync  <= 1'b0;
            err   <= 1'b0;
        end else if (rdy) begin
            if (rcyc) begin
                cycle <= 3'd0;
                inst  <= inject ? INT_OP : data_in;
                sync  <= 1'b1;
            end else begin
                sync <= 1'b0;
                if (icyc) begin
                    // Eight cycles is the architectural maximum; wrapping is a decoder bug.
                    if (cycle == 3'd7) begin
                        err <= 1'b1;
                    end
                    cycle <= cycle + 3'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_cycle_sequencer.sv
// Directed plus randomized bench for cycle_sequencer, checked against a
// request-priority reference model kept in the bench.
module tb_cycle_sequencer;

    localparam logic [7:0] INT_OP = 8'h00;

    logic       clk;
    logic       clr;
    logic       rdy;
    logic       icyc;
    logic       rcyc;
    logic       sinst;
    logic [7:0] data_in;
    logic       irq;
    logic       nmi;
    logic       idis;
    logic [2:0] cycle;
    logic [7:0] inst;
    logic       clr_o;
    logic       nmi_o;
    logic       irq_o;
    logic       sync;
    logic       err;

    int total = 0;
    int bad   = 0;

    cycle_sequencer #(.INT_OP(INT_OP)) dut (
        .clk(clk), .clr(clr), .rdy(rdy), .icyc(icyc), .rcyc(rcyc), .sinst(sinst),
        .data_in(data_in), .irq(irq), .nmi(nmi), .idis(idis),
        .cycle(cycle), .inst(inst), .clr_o(clr_o), .nmi_o(nmi_o), .irq_o(irq_o),
        .sync(sync), .err(err)
    );

    // clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // reference model: pending requests as flags, active request as a priority rank
    int         m_cycle;
    logic [7:0] m_inst;
    bit         m_sync, m_err, m_reset_req, m_nmi_req, m_nmi_last;

    function automatic int active_req();
        if (m_reset_req) return 1;
        if (m_nmi_req) return 2;
        if (irq && !idis) return 3;
        return 0;
    endfunction

    task automatic model_reset();
        m_cycle = 0; m_inst = INT_OP; m_sync = 0; m_err = 0;
        m_reset_req = 1; m_nmi_req = 0; m_nmi_last = 0;
    endtask

    task automatic model_clock();
        int k;
        k = active_req();
        if (rdy && sinst && m_cycle == 0) begin
            if (k == 1) m_reset_req = 0;
            if (k == 2) m_nmi_req = 0;
        end
        if (nmi && !m_nmi_last) m_nmi_req = 1;
        m_nmi_last = nmi;
        if (rdy) begin
            if (rcyc) begin
                m_cycle = 0;
                m_inst  = (k != 0) ? INT_OP : data_in;
                m_sync  = 1;
            end else begin
                m_sync = 0;
                if (icyc) begin
                    if (m_cycle == 7) m_err = 1;
                    m_cycle = (m_cycle + 1) % 8;
                end
            end
        end
    endtask

    // scoreboard
    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        int k;
        k = active_req();
        chk("cycle", {5'd0, cycle}, 8'(m_cycle));
        chk("inst", inst, m_inst);
        chk("sync", {7'd0, sync}, {7'd0, m_sync});
        chk("err", {7'd0, err}, {7'd0, m_err});
        chk("clr_o", {7'd0, clr_o}, {7'd0, k == 1});
        chk("nmi_o", {7'd0, nmi_o}, {7'd0, k == 2});
        chk("irq_o", {7'd0, irq_o}, {7'd0, k == 3});
    endtask

    // driver tasks: inputs change on the falling edge, outputs checked before the rising edge
    task automatic tick();
        #1 check_all();
        @(posedge clk);
        model_clock();
        @(negedge clk);
    endtask

    task automatic set_ctl(input logic r, input logic ic, input logic rc, input logic si,
                           input logic [7:0] d);
        rdy = r; icyc = ic; rcyc = rc; sinst = si; data_in = d;
    endtask

    task automatic apply_reset();
        clr = 1'b0;
        #1;
        model_reset();
        check_all();
        @(negedge clk);
        @(negedge clk);
        clr = 1'b1;
    endtask

    initial begin
        clr = 1'b1;
        set_ctl(1, 0, 0, 0, 8'h00);
        irq = 0; nmi = 0; idis = 0;
        model_reset();
        @(negedge clk);
        apply_reset();

        // reset vector sequence, then fetch of A9
        chk("rst_inst", inst, INT_OP);
        chk("rst_clr_o", {7'd0, clr_o}, 8'd1);
        set_ctl(1, 0, 0, 1, 8'h00); tick();
        chk("clr_o_fell", {7'd0, clr_o}, 8'd0);
        for (int i = 0; i < 6; i++) begin set_ctl(1, 1, 0, 0, 8'h00); tick(); end
        chk("cycle6", {5'd0, cycle}, 8'd6);
        set_ctl(1, 0, 1, 0, 8'hA9); tick();
        chk("inst_a9", inst, 8'hA9);
        chk("sync_set", {7'd0, sync}, 8'd1);
        set_ctl(1, 0, 0, 0, 8'h00); tick();
        chk("sync_one", {7'd0, sync}, 8'd0);

        // NMI arrives during cycle 2 of opcode 69 while IRQ is also up
        set_ctl(1, 0, 1, 0, 8'h69); tick();
        set_ctl(1, 1, 0, 0, 8'h00); tick(); tick();
        irq = 1; nmi = 1; set_ctl(1, 0, 0, 0, 8'h00); tick();
        chk("nmi_o_up", {7'd0, nmi_o}, 8'd1);
        chk("irq_o_masked", {7'd0, irq_o}, 8'd0);
        chk("inst_69", inst, 8'h69);
        set_ctl(1, 1, 0, 0, 8'h00); tick();
        set_ctl(1, 0, 1, 0, 8'h55); tick();
        chk("nmi_inject", inst, 8'h00);
        set_ctl(1, 0, 0, 1, 8'h00); tick();
        chk("nmi_ack", {7'd0, nmi_o}, 8'd0);
        chk("irq_after_nmi", {7'd0, irq_o}, 8'd1);

        // IRQ held off by idis, then released
        idis = 1; #1;
        chk("irq_disabled", {7'd0, irq_o}, 8'd0);
        set_ctl(1, 0, 1, 0, 8'hEA); tick();
        chk("inst_ea", inst, 8'hEA);
        idis = 0; set_ctl(1, 0, 0, 0, 8'h00); tick();
        set_ctl(1, 0, 1, 0, 8'hEA); tick();
        chk("irq_inject", inst, 8'h00);
        irq = 0; nmi = 0;

        // rcyc beats icyc; rdy low freezes the counter
        for (int i = 0; i < 3; i++) begin set_ctl(1, 1, 0, 0, 8'h00); tick(); end
        set_ctl(1, 1, 1, 0, 8'h33); tick();
        chk("rcyc_prio", {5'd0, cycle}, 8'd0);
        set_ctl(1, 1, 0, 0, 8'h00); tick();
        for (int i = 0; i < 4; i++) begin set_ctl(0, 1, 1, 0, 8'h77); tick(); end
        chk("frozen_cycle", {5'd0, cycle}, 8'd1);
        chk("frozen_inst", inst, 8'h33);

        // overflow wraps and err is sticky until reset
        set_ctl(1, 0, 1, 0, 8'h11); tick();
        for (int i = 0; i < 8; i++) begin set_ctl(1, 1, 0, 0, 8'h00); tick(); end
        chk("wrap_cycle", {5'd0, cycle}, 8'd0);
        chk("err_set", {7'd0, err}, 8'd1);
        set_ctl(1, 0, 1, 0, 8'h22); tick();
        chk("err_sticky", {7'd0, err}, 8'd1);

        // reset mid-instruction with an NMI pending
        for (int i = 0; i < 4; i++) begin set_ctl(1, 1, 0, 0, 8'h00); tick(); end
        nmi = 1; set_ctl(1, 0, 0, 0, 8'h00); tick();
        chk("nmi_pending", {7'd0, nmi_o}, 8'd1);
        #3;
        apply_reset();
        chk("abort_cycle", {5'd0, cycle}, 8'd0);
        chk("abort_err", {7'd0, err}, 8'd0);
        nmi = 0;

        // randomized traffic
        for (int n = 0; n < 600; n++) begin
            set_ctl(($urandom_range(0, 9) != 0), $urandom_range(0, 1),
                    ($urandom_range(0, 5) == 0), (m_cycle == 0) && ($urandom_range(0, 1) == 1),
                    8'($urandom_range(0, 255)));
            irq  = ($urandom_range(0, 2) == 0);
            idis = $urandom_range(0, 1);
            if ($urandom_range(0, 7) == 0) nmi = ~nmi;
            if ($urandom_range(0, 99) == 0) begin
                #2;
                apply_reset();
            end else begin
                tick();
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cycle_sequencer.md
CYCLE_SEQUENCER -- requirements
Module: cycle_sequencer

Interface
REQ-001 The block SHALL have a parameter INT_OP, default 8'h00, giving the opcode injected for reset/NMI/IRQ sequences.
REQ-002 The block SHALL have a port clk  in  1  sole clock; all state changes on its rising edge.
REQ-003 The block SHALL have a port clr  in  1  asynchronous, active-low reset.
REQ-004 The block SHALL have a port rdy  in  1  advance enable; low freezes cycle/inst.
REQ-005 The block SHALL have a port icyc  in  1  decoder request: increment cycle.
REQ-006 The block SHALL have a port rcyc  in  1  decoder request: end instruction, fetch next.
REQ-007 The block SHALL have a port sinst  in  1  decoder acknowledge of an interrupt-type sequence start.
REQ-008 The block SHALL have a port data_in  in  8  data-bus byte present during opcode fetch.
REQ-009 The block SHALL have a port irq  in  1  level interrupt request, active-high.
REQ-010 The block SHALL have a port nmi  in  1  non-maskable request, rising-edge sensitive.
REQ-011 The block SHALL have a port idis  in  1  status-register interrupt-disable flag.
REQ-012 The block SHALL have a port cycle  out  3  current instruction cycle to decoder.
REQ-013 The block SHALL have a port inst  out  8  current instruction register to decoder.
REQ-014 The block SHALL have a port clr_o  out  1  pending-reset request to decoder.
REQ-015 The block SHALL have a port nmi_o  out  1  pending-NMI request to decoder.
REQ-016 The block SHALL have a port irq_o  out  1  qualified IRQ request to decoder.
REQ-017 The block SHALL have a port sync  out  1  high for the first cycle (cycle 0) of each newly fetched instruction.
REQ-018 The block SHALL have a port err  out  1  sticky cycle-overflow flag.

Function
REQ-019 Cycle counter, when rdy=1:
- rcyc=1 -> cycle := 0; rcyc takes priority over icyc.
- else icyc=1 -> cycle := cycle+1.
- neither -> cycle holds.
REQ-020 icyc at cycle=7 (rcyc=0, rdy=1) SHALL wrap cycle to 0 and set err; err clears only on reset.
REQ-021 On an accepted rcyc, inst SHALL load INT_OP if clr_o, nmi_o or irq_o is high in that cycle, otherwise data_in; sync := 1 for exactly the next cycle.
REQ-022 rdy=0 SHALL hold cycle, inst and sync; interrupt capture (REQ-023..025) SHALL continue.
REQ-023 nmi is registered each clk; a 0->1 transition sets nmi_pend; nmi_pend clears when sinst=1, cycle=0, nmi_o=1, rdy=1.
REQ-024 A new nmi edge coincident with the clearing condition SHALL leave nmi_pend set.
REQ-025 clr_pend is set by reset and clears when sinst=1, cycle=0, clr_o=1, rdy=1.
REQ-026 Priority, outputs mutually exclusive (one-hot or zero):
- clr_o = clr_pend.
- nmi_o = nmi_pend & ~clr_pend.
- irq_o = irq & ~idis & ~clr_pend & ~nmi_pend; combinational, not latched.
REQ-027 An irq dropped before rcyc SHALL NOT cause injection; idis rising before rcyc SHALL likewise suppress it.
REQ-028 Requests arriving mid-instruction SHALL NOT alter cycle or inst until the next accepted rcyc.
REQ-029 inst/cycle updates SHALL be registered (1-cycle latency from rcyc/icyc).

Reset
REQ-030 While clr=0 (asynchronously):
- cycle=0, inst=INT_OP, clr_pend=1, nmi_pend=0, nmi history=0, sync=0, err=0.
- Hence clr_o=1, nmi_o=0, irq_o=0.
REQ-031 After release, the decoder SHALL see inst=INT_OP, cycle=0, clr_o=1, so the reset-vector sequence runs first.
REQ-032 Reset asserted mid-instruction SHALL abort it; no partial state survives.

Verification
REQ-033 Reset release, decoder pulses sinst at cycle 0, icyc x6, rcyc with data_in=8'hA9 -> clr_o falls after sinst; cycle 0..6 then 0; inst=8'hA9, sync=1 for one cycle.
REQ-034 nmi rises during cycle 2 of 8'h69, irq=1, idis=0 -> nmi_o=1, irq_o=0; next rcyc loads inst=8'h00; sinst at cycle 0 clears nmi_o; irq_o then 1.
REQ-035 irq=1, idis=1 through rcyc with data_in=8'hEA -> irq_o=0, inst=8'hEA; idis=0 -> irq_o=1; next rcyc -> inst=8'h00.
REQ-036 icyc and rcyc both high at cycle 3 -> cycle=0; rdy=0 with icyc high for 4 clocks -> cycle, inst, sync unchanged.
REQ-037 icyc held at cycle 7 -> cycle=0, err=1, err stays 1 until clr=0.
REQ-038 clr pulsed low at cycle 4 with nmi_pend=1 -> immediately cycle=0, inst=8'h00, clr_o=1, nmi_o=0.
